// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller: coin codes and values, FSM states, credit width.
package vend_pkg;

  localparam int unsigned CREDIT_W = 8;

  localparam logic [1:0] COIN_NICKEL  = 2'b00;
  localparam logic [1:0] COIN_DIME    = 2'b01;
  localparam logic [1:0] COIN_QUARTER = 2'b10;
  localparam logic [1:0] COIN_DOLLAR  = 2'b11;

  localparam logic [CREDIT_W-1:0] VAL_NICKEL  = 8'd5;
  localparam logic [CREDIT_W-1:0] VAL_DIME    = 8'd10;
  localparam logic [CREDIT_W-1:0] VAL_QUARTER = 8'd25;
  localparam logic [CREDIT_W-1:0] VAL_DOLLAR  = 8'd100;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_e;

  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_NICKEL:  coin_value = VAL_NICKEL;
      COIN_DIME:    coin_value = VAL_DIME;
      COIN_QUARTER: coin_value = VAL_QUARTER;
      default:      coin_value = VAL_DOLLAR;
    endcase
  endfunction

endpackage

// File: rtl/vend_timer.sv
// Loadable down-counter shared by the COLLECT inactivity timeout and the dispense pulse width.
module vend_timer #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expired_c
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign expired_c = (count == '0);

endmodule

// File: rtl/vend_controller.sv
// Vending sequencer: coin credit, product select, dispense pulse, change handshake, idle refund.
// Optional VEND_SALES_COUNT_EN adds a saturating sales_count output.
module vend_controller
  import vend_pkg::*;
#(
  parameter int unsigned PRICE        = 75,
  parameter int unsigned MAX_CREDIT   = 255,
  parameter int unsigned TIMEOUT_CYC  = 1000,
  parameter int unsigned DISPENSE_CYC = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                sel,
  input  logic                cancel,
  input  logic                change_ack,
  output logic                coin_reject,
  output logic                dispense,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
`ifdef VEND_SALES_COUNT_EN
  ,
  output logic [15:0]         sales_count
`endif
);

  localparam int unsigned SUM_W   = CREDIT_W + 1;
  localparam int unsigned TMR_MAX = (TIMEOUT_CYC > DISPENSE_CYC) ? TIMEOUT_CYC : DISPENSE_CYC;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  state_e              state;
  logic [CREDIT_W-1:0] coin_val;
  logic [SUM_W-1:0]    credit_sum;
  logic                coin_fits;
  logic                sel_ok;
  logic                coin_ok;
  logic                tmr_load;
  logic                tmr_en;
  logic [TMR_W-1:0]    tmr_load_val;
  logic                tmr_expired;

  assign coin_val   = coin_value(coin_type);
  assign credit_sum = {1'b0, credit} + {1'b0, coin_val};
  assign coin_fits  = (credit_sum <= SUM_W'(MAX_CREDIT));
  assign coin_ok    = coin_valid && coin_fits;
  assign sel_ok     = sel && (credit >= CREDIT_W'(PRICE));

  // Timer control mirrors the FSM priority: cancel > sel > coin > count down.
  always_comb begin
    tmr_load     = 1'b0;
    tmr_en       = 1'b0;
    tmr_load_val = '0;
    case (state)
      IDLE: begin
        if (coin_ok) begin
          tmr_load     = 1'b1;
          tmr_load_val = TMR_W'(TIMEOUT_CYC - 1);
        end
      end
      COLLECT: begin
        if (cancel) begin
          tmr_load = 1'b0;
        end else if (sel_ok) begin
          tmr_load     = 1'b1;
          tmr_load_val = TMR_W'(DISPENSE_CYC - 1);
        end else if (coin_ok) begin
          tmr_load     = 1'b1;
          tmr_load_val = TMR_W'(TIMEOUT_CYC - 1);
        end else begin
          tmr_en = 1'b1;
        end
      end
      DISPENSE: tmr_en = 1'b1;
      default:  tmr_en = 1'b0;
    endcase
  end

  vend_timer #(
    .W(TMR_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_load_val),
    .expired_c(tmr_expired)
  );

  // Sequencer with registered outputs; credit stays visible in CHANGE until the ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      credit       <= '0;
      coin_reject  <= 1'b0;
      dispense     <= 1'b0;
      change_valid <= 1'b0;
      change_amt   <= '0;
      busy         <= 1'b0;
`ifdef VEND_SALES_COUNT_EN
      sales_count  <= '0;
`endif
    end else begin
      coin_reject <= 1'b0;
      case (state)
        IDLE: begin
          if (coin_valid) begin
            if (coin_fits) begin
              credit <= coin_val;
              state  <= COLLECT;
            end else begin
              coin_reject <= 1'b1;
            end
          end
        end
        COLLECT: begin
          if (cancel) begin
            coin_reject  <= coin_valid;
            change_amt   <= credit;
            change_valid <= 1'b1;
            busy         <= 1'b1;
            state        <= CHANGE;
          end else if (sel_ok) begin
            coin_reject <= coin_valid;
            credit      <= credit - CREDIT_W'(PRICE);
            dispense    <= 1'b1;
            busy        <= 1'b1;
            state       <= DISPENSE;
`ifdef VEND_SALES_COUNT_EN
            if (sales_count != 16'hFFFF) sales_count <= sales_count + 16'd1;
`endif
          end else if (coin_ok) begin
            credit <= credit_sum[CREDIT_W-1:0];
          end else begin
            coin_reject <= coin_valid;
            if (tmr_expired) begin
              change_amt   <= credit;
              change_valid <= 1'b1;
              busy         <= 1'b1;
              state        <= CHANGE;
            end
          end
        end
        DISPENSE: begin
          coin_reject <= coin_valid;
          if (tmr_expired) begin
            dispense <= 1'b0;
            if (credit != '0) begin
              change_amt   <= credit;
              change_valid <= 1'b1;
              state        <= CHANGE;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        CHANGE: begin
          coin_reject <= coin_valid;
          if (change_ack) begin
            credit       <= '0;
            change_valid <= 1'b0;
            change_amt   <= '0;
            busy         <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Self-checking bench for vend_controller: directed scenarios plus random traffic against a behavioural model.
module tb_vend_controller;

  localparam int PRICE        = 75;
  localparam int MAX_CREDIT   = 255;
  localparam int TIMEOUT_CYC  = 1000;
  localparam int DISPENSE_CYC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_type = 2'b00;
  logic       sel = 1'b0;
  logic       cancel = 1'b0;
  logic       change_ack = 1'b0;
  logic       coin_reject;
  logic       dispense;
  logic       change_valid;
  logic [7:0] change_amt;
  logic [7:0] credit;
  logic       busy;
`ifdef VEND_SALES_COUNT_EN
  logic [15:0] sales_count;
`endif

  vend_controller #(
    .PRICE       (PRICE),
    .MAX_CREDIT  (MAX_CREDIT),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .DISPENSE_CYC(DISPENSE_CYC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .coin_valid  (coin_valid),
    .coin_type   (coin_type),
    .sel         (sel),
    .cancel      (cancel),
    .change_ack  (change_ack),
    .coin_reject (coin_reject),
    .dispense    (dispense),
    .change_valid(change_valid),
    .change_amt  (change_amt),
    .credit      (credit),
    .busy        (busy)
`ifdef VEND_SALES_COUNT_EN
    ,
    .sales_count (sales_count)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: credit, idle count, remaining vend cycles, pending refund.
  int m_credit, m_idle, m_vend_left, m_chg, m_sales;
  bit m_pending, m_reject;
  int disp_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int cents(input logic [1:0] code);
    case (code)
      2'd0:    return 5;
      2'd1:    return 10;
      2'd2:    return 25;
      default: return 100;
    endcase
  endfunction

  task automatic model_reset();
    m_credit = 0; m_idle = 0; m_vend_left = 0; m_chg = 0;
    m_pending = 0; m_reject = 0; m_sales = 0;
  endtask

  task automatic model_step(input bit cv, input logic [1:0] ct, input bit s, input bit c, input bit a);
    int v;
    v = cents(ct);
    m_reject = 0;
    if (m_vend_left > 0) begin
      m_reject = cv;
      m_vend_left--;
      if (m_vend_left == 0 && m_credit > 0) begin
        m_pending = 1; m_chg = m_credit;
      end
    end else if (m_pending) begin
      m_reject = cv;
      if (a) begin m_pending = 0; m_credit = 0; end
    end else if (m_credit == 0) begin
      if (cv) begin
        if (v <= MAX_CREDIT) begin m_credit = v; m_idle = 0; end
        else m_reject = 1;
      end
    end else begin
      if (c) begin
        m_reject = cv; m_pending = 1; m_chg = m_credit;
      end else if (s && m_credit >= PRICE) begin
        m_reject = cv; m_credit -= PRICE; m_vend_left = DISPENSE_CYC;
        if (m_sales < 65535) m_sales++;
      end else if (cv && m_credit + v <= MAX_CREDIT) begin
        m_credit += v; m_idle = 0;
      end else begin
        m_reject = cv;
        m_idle++;
        if (m_idle == TIMEOUT_CYC) begin m_pending = 1; m_chg = m_credit; end
      end
    end
  endtask

  task automatic compare_all();
    check("credit", 32'(credit), 32'(m_credit));
    check("dispense", 32'(dispense), 32'(m_vend_left > 0));
    check("change_valid", 32'(change_valid), 32'(m_pending));
    check("busy", 32'(busy), 32'(m_vend_left > 0 || m_pending));
    check("coin_reject", 32'(coin_reject), 32'(m_reject));
    if (m_pending) check("change_amt", 32'(change_amt), 32'(m_chg));
`ifdef VEND_SALES_COUNT_EN
    check("sales_count", 32'(sales_count), 32'(m_sales));
`endif
    if (dispense) disp_seen++;
  endtask

  // Drive at the falling edge, update the model at the rising edge, check at the next falling edge.
  task automatic cycle(input bit cv, input logic [1:0] ct, input bit s, input bit c, input bit a);
    coin_valid = cv; coin_type = ct; sel = s; cancel = c; change_ack = a;
    @(posedge clk);
    model_step(cv, ct, s, c, a);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 2'd0, 0, 0, 0);
  endtask

  task automatic coin(input logic [1:0] ct);
    cycle(1, ct, 0, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    model_reset();
    #3;
    check("rst_credit", 32'(credit), 0);
    check("rst_dispense", 32'(dispense), 0);
    check("rst_change_valid", 32'(change_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_coin_reject", 32'(coin_reject), 0);
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    idle(2);

    // Three quarters then select: exact price, no change.
    disp_seen = 0;
    coin(2'd2); coin(2'd2); coin(2'd2);
    check("credit_75", 32'(credit), 75);
    cycle(0, 2'd0, 1, 0, 0);
    idle(DISPENSE_CYC + 2);
    check("disp_width", 32'(disp_seen), 32'(DISPENSE_CYC));

    // Dollar then select: change of 25 held until ack.
    coin(2'd3);
    cycle(0, 2'd0, 1, 0, 0);
    idle(DISPENSE_CYC + 3);
    check("chg_25", 32'(change_amt), 25);
    cycle(0, 2'd0, 0, 0, 1);
    idle(1);

    // Dime, dime, cancel: refund 20.
    coin(2'd1); coin(2'd1);
    cycle(0, 2'd0, 0, 1, 0);
    check("refund_20", 32'(change_amt), 20);
    idle(2);
    cycle(0, 2'd0, 0, 0, 1);

    // Nickel, full timeout refund; then a coin at cycle 999 restarts it.
    coin(2'd0);
    idle(TIMEOUT_CYC);
    check("timeout_valid", 32'(change_valid), 1);
    check("timeout_amt", 32'(change_amt), 5);
    cycle(0, 2'd0, 0, 0, 1);
    coin(2'd0);
    idle(TIMEOUT_CYC - 2);
    coin(2'd0);
    idle(TIMEOUT_CYC - 1);
    check("restart_no_refund", 32'(change_valid), 0);
    idle(1);
    check("restart_refund", 32'(change_amt), 10);
    cycle(0, 2'd0, 0, 0, 1);

    // Credit 200 then dollar rejected; coin + sel at 75 vends and rejects the coin.
    coin(2'd3); coin(2'd3); coin(2'd3);
    check("reject_pulse", 32'(coin_reject), 1);
    check("credit_200", 32'(credit), 200);
    cycle(0, 2'd0, 0, 1, 0);
    cycle(0, 2'd0, 0, 0, 1);
    coin(2'd2); coin(2'd2); coin(2'd2);
    cycle(1, 2'd1, 1, 0, 0);
    check("coin_sel_reject", 32'(coin_reject), 1);
    idle(DISPENSE_CYC + 1);

    // Asynchronous reset during dispense cycle 2.
    coin(2'd3);
    cycle(0, 2'd0, 1, 0, 0);
    idle(1);
    #1 reset = 1'b0;
    #1;
    check("async_dispense", 32'(dispense), 0);
    check("async_change_valid", 32'(change_valid), 0);
    check("async_credit", 32'(credit), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    coin(2'd1);
    check("post_reset_credit", 32'(credit), 10);
    cycle(0, 2'd0, 0, 1, 0);
    cycle(0, 2'd0, 0, 0, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(99) < 25), 2'($urandom_range(3)), ($urandom_range(99) < 10),
            ($urandom_range(99) < 3), ($urandom_range(99) < 30));
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vend_controller.md
Name: vend_controller

Overview:
- Sequencing controller for the vending machine: accumulates coin credit, accepts a product select, times the dispense pulse and returns change through a valid/ack handshake.
- Sits between the coin/button front end and the dispense/change actuators.
- Owns the inactivity timeout that refunds abandoned credit.

Parameters:
- PRICE, 75, product price in cents; must be ≤ MAX_CREDIT and a multiple of 5.
- MAX_CREDIT, 255, credit ceiling in cents; must be ≤ 255 to fit 8 bits.
- TIMEOUT_CYC, 1000, idle cycles in COLLECT before automatic refund; must be ≥ 1.
- DISPENSE_CYC, 4, width in cycles of the dispense pulse; must be ≥ 1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = reset asserted.
- coin_valid  in  1  single-cycle coin strobe.
- coin_type  in  2  coin code: 00 = 5, 01 = 10, 10 = 25, 11 = 100 cents.
- sel  in  1  single-cycle product-select strobe.
- cancel  in  1  single-cycle refund request.
- change_ack  in  1  change actuator has taken change_amt.
- coin_reject  out  1  one-cycle pulse when a coin is not accepted.
- dispense  out  1  high for exactly DISPENSE_CYC cycles per vend.
- change_valid  out  1  change_amt is valid; held until acked.
- change_amt  out  8  change or refund amount in cents.
- credit  out  8  current credit in cents.
- busy  out  1  high in DISPENSE and CHANGE.

Behaviour:
- Reset (reset = 0, any state, mid-operation included): state = IDLE; credit = 0; timer cleared; all outputs 0. Outputs take reset values immediately, with no clock required. Any in-flight dispense or change is abandoned.
- States are IDLE, COLLECT, DISPENSE, CHANGE.
- IDLE:
  - coin_valid accepted: credit = coin value, go to COLLECT.
  - sel and cancel are ignored.
- COLLECT:
  - Accepted coin: credit += value, timer reloads to TIMEOUT_CYC.
  - A coin that would push credit above MAX_CREDIT is rejected: credit unchanged, coin_reject pulses for 1 cycle.
  - sel with credit ≥ PRICE: credit -= PRICE, go to DISPENSE. dispense rises on the next cycle.
  - sel with credit < PRICE: ignored.
  - cancel, or timer expiry: go to CHANGE with change_amt = credit.
- Priority in a single cycle: cancel > sel > coin_valid. A coin arriving in the same cycle as cancel or an accepted sel is rejected with a coin_reject pulse.
- DISPENSE:
  - dispense is high for exactly DISPENSE_CYC cycles.
  - Next state is CHANGE if credit > 0, otherwise IDLE.
  - Coins pulse coin_reject; sel and cancel are ignored.
- CHANGE:
  - On entry, change_amt = credit and change_valid = 1.
  - change_valid and change_amt stay stable until change_ack is sampled high.
  - On ack: credit = 0, change_valid = 0, go to IDLE.
  - Coins pulse coin_reject.
- Timer counts only in COLLECT. Expiry means TIMEOUT_CYC consecutive cycles with no accepted coin.
- change_ack is ignored outside CHANGE.
- Arithmetic: all credit arithmetic is unsigned 8-bit. Overflow is prevented by the reject rule, so there is no wrap-around.
- Latency: every input takes effect at the next rising clk edge.

Optional Feature:
- Macro: VEND_SALES_COUNT_EN.
- Defined:
  - Adds output port sales_count[15:0].
  - Increments by 1 on each entry to DISPENSE and saturates at 16'hFFFF.
  - Reset value is 0.
- Undefined: the port and its counter logic are absent. All other behaviour is identical.

Decomposition:
- Package vend_pkg holds:
  - Coin codes.
  - Coin value constants (5/10/25/100).
  - State enum (IDLE, COLLECT, DISPENSE, CHANGE).
  - Credit width constant (8).
- Sub-module vend_timer: a loadable down-counter with load, enable and expired signals. It is shared between the timeout and the dispense pulse-width count, which are never active together.

Test Plan:
- Quarter ×3, then sel → credit 25/50/75; dispense high for 4 cycles; credit 0; return to IDLE; change_valid never asserts.
- Dollar, then sel → dispense for 4 cycles; then change_valid = 1 with change_amt = 25, held until change_ack; credit 0.
- Dime, dime, cancel → change_valid with change_amt = 20; no dispense.
- Nickel, then 1000 idle cycles → automatic refund with change_amt = 5. A second run adding a coin at cycle 999 restarts the timeout.
- Credit 200, insert dollar → coin_reject pulse, credit stays 200. Coin + sel in the same cycle with credit 75 → vend, coin rejected.
- Assert reset during DISPENSE cycle 2 → dispense, change_valid and credit all 0 immediately (asynchronous); state IDLE after release.
